// File: rtl/zeroasic_dsp_macc_pipe.sv
// ----------------------------------------------------------------------------
// zeroasic_dsp_macc_pipe
//
// Parametrised multiply / multiply-add / multiply-accumulate pipeline for the
// Z1010 DSP tile. A valid bit travels with every sample. The pipeline has an
// optional input register stage (p0) and an optional multiplier register
// stage (p1), followed by an always-registered output stage that holds the
// result. In accumulate mode the result register P is the accumulator.
//
// Ports:
//   CLK       in   1        rising-edge clock
//   ARST_N    in   1        asynchronous active-low reset (all registers to 0)
//   EN        in   1        clock enable; 0 freezes every stage
//   CLR       in   1        synchronous clear of valids, P and OVF (ignores EN)
//   IN_VALID  in   1        A/B/C/ACC_LOAD carry a sample this cycle
//   A         in   A_WIDTH  multiplicand
//   B         in   B_WIDTH  multiplier
//   C         in   C_WIDTH  addend (MODE 1) or accumulator preload (MODE 2)
//   ACC_LOAD  in   1        MODE 2: restart accumulation at A*B+C
//   OUT_VALID out  1        P holds a new result
//   P         out  P_WIDTH  result / accumulator register
//   OVF       out  1        overflow flag (sticky while accumulating)
//
// Latency is IN_REG + MULT_REG + 1 enabled edges.
// ----------------------------------------------------------------------------
module zeroasic_dsp_macc_pipe #(
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 18,
    parameter int C_WIDTH  = 40,
    parameter int P_WIDTH  = 40,
    parameter int IN_REG   = 1,
    parameter int MULT_REG = 1,
    parameter int MODE     = 2,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 0
) (
    input  logic               CLK,
    input  logic               ARST_N,
    input  logic               EN,
    input  logic               CLR,
    input  logic               IN_VALID,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic [C_WIDTH-1:0] C,
    input  logic               ACC_LOAD,
    output logic               OUT_VALID,
    output logic [P_WIDTH-1:0] P,
    output logic               OVF
);

    // Adds two P_WIDTH operands and returns {overflow, result}. In signed
    // mode the sum is formed one bit wider so the true sign is visible; that
    // bit picks the violated bound when clamping. Unsigned addition can only
    // overflow upwards, so the clamp value is all-ones.
    function automatic logic [P_WIDTH:0] add_sat(input logic [P_WIDTH-1:0] x,
                                                 input logic [P_WIDTH-1:0] y);
        logic signed [P_WIDTH:0] ssum;
        logic        [P_WIDTH:0] usum;
        logic                    ovf;
        logic [P_WIDTH-1:0]      res;
        if (SIGNED != 0) begin
            ssum = $signed({x[P_WIDTH-1], x}) + $signed({y[P_WIDTH-1], y});
            res  = ssum[P_WIDTH-1:0];
            ovf  = ssum[P_WIDTH] != ssum[P_WIDTH-1];
            if (ovf && (SATURATE != 0)) begin
                res = ssum[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                    : {1'b0, {(P_WIDTH-1){1'b1}}};
            end
        end else begin
            usum = {1'b0, x} + {1'b0, y};
            res  = usum[P_WIDTH-1:0];
            ovf  = usum[P_WIDTH];
            if (ovf && (SATURATE != 0)) begin
                res = '1;
            end
        end
        return {ovf, res};
    endfunction

    logic [A_WIDTH-1:0] a_p0;
    logic [B_WIDTH-1:0] b_p0;
    logic [C_WIDTH-1:0] c_p0;
    logic               ld_p0;
    logic               vld_p0;

    // ---- stage p0: optional input register ----
    generate
        if (IN_REG != 0) begin : g_in_reg
            always_ff @(posedge CLK or negedge ARST_N) begin
                if (!ARST_N) begin
                    vld_p0 <= 1'b0;
                    a_p0   <= '0;
                    b_p0   <= '0;
                    c_p0   <= '0;
                    ld_p0  <= 1'b0;
                end else begin
                    if (CLR) begin
                        vld_p0 <= 1'b0;
                    end else if (EN) begin
                        vld_p0 <= IN_VALID;
                    end
                    if (EN) begin
                        a_p0  <= A;
                        b_p0  <= B;
                        c_p0  <= C;
                        ld_p0 <= ACC_LOAD;
                    end
                end
            end
        end else begin : g_in_comb
            // A CLR in this cycle clears the downstream register that would
            // otherwise capture this sample, so the sample is dropped there.
            assign vld_p0 = IN_VALID;
            assign a_p0   = A;
            assign b_p0   = B;
            assign c_p0   = C;
            assign ld_p0  = ACC_LOAD;
        end
    endgenerate

    // Operands are extended to P_WIDTH before multiplying. Because the full
    // product fits in P_WIDTH bits, the low P_WIDTH bits of the product are
    // exact for both signed and unsigned operands.
    logic [P_WIDTH-1:0] a_ext;
    logic [P_WIDTH-1:0] b_ext;
    logic [P_WIDTH-1:0] c_ext;
    logic [P_WIDTH-1:0] mult_prod;

    always_comb begin
        a_ext = {P_WIDTH{(SIGNED != 0) && a_p0[A_WIDTH-1]}};
        a_ext[A_WIDTH-1:0] = a_p0;
        b_ext = {P_WIDTH{(SIGNED != 0) && b_p0[B_WIDTH-1]}};
        b_ext[B_WIDTH-1:0] = b_p0;
        c_ext = {P_WIDTH{(SIGNED != 0) && c_p0[C_WIDTH-1]}};
        c_ext[C_WIDTH-1:0] = c_p0;
        mult_prod = a_ext * b_ext;
    end

    logic [P_WIDTH-1:0] prod_p1;
    logic [P_WIDTH-1:0] c_p1;
    logic               ld_p1;
    logic               vld_p1;

    // ---- stage p1: optional multiplier output register ----
    generate
        if (MULT_REG != 0) begin : g_mult_reg
            always_ff @(posedge CLK or negedge ARST_N) begin
                if (!ARST_N) begin
                    vld_p1  <= 1'b0;
                    prod_p1 <= '0;
                    c_p1    <= '0;
                    ld_p1   <= 1'b0;
                end else begin
                    if (CLR) begin
                        vld_p1 <= 1'b0;
                    end else if (EN) begin
                        vld_p1 <= vld_p0;
                    end
                    if (EN) begin
                        prod_p1 <= mult_prod;
                        c_p1    <= c_ext;
                        ld_p1   <= ld_p0;
                    end
                end
            end
        end else begin : g_mult_comb
            assign vld_p1  = vld_p0;
            assign prod_p1 = mult_prod;
            assign c_p1    = c_ext;
            assign ld_p1   = ld_p0;
        end
    endgenerate

    // Accumulating samples add onto P itself; loads and MODE 1 add C.
    logic [P_WIDTH-1:0] add_base;
    logic [P_WIDTH:0]   add_res;

    always_comb begin
        add_base = c_p1;
        if ((MODE == 2) && !ld_p1) begin
            add_base = P;
        end
        add_res = add_sat(prod_p1, add_base);
    end

    // ---- stage p2: output / accumulator register ----
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            OUT_VALID <= 1'b0;
            P         <= '0;
            OVF       <= 1'b0;
        end else if (CLR) begin
            OUT_VALID <= 1'b0;
            P         <= '0;
            OVF       <= 1'b0;
        end else if (EN) begin
            OUT_VALID <= vld_p1;
            if (vld_p1) begin
                case (MODE)
                    0: begin
                        P   <= prod_p1;
                        OVF <= 1'b0;
                    end
                    1: begin
                        P   <= add_res[P_WIDTH-1:0];
                        OVF <= add_res[P_WIDTH];
                    end
                    default: begin
                        P   <= add_res[P_WIDTH-1:0];
                        OVF <= ld_p1 ? add_res[P_WIDTH] : (OVF | add_res[P_WIDTH]);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zeroasic_dsp_macc_pipe.sv
// ----------------------------------------------------------------------------
// tb_zeroasic_dsp_macc_pipe
//
// Five instances share one stimulus stream:
//   u_m0  : MODE 0, signed, L=3
//   u_m1  : MODE 1, signed, L=3
//   u_m2  : MODE 2, signed, wrapping, L=3
//   u_m2s : MODE 2, signed, saturating, L=3
//   u_u   : MODE 0, unsigned, no optional registers, L=1
// ----------------------------------------------------------------------------
module tb_zeroasic_dsp_macc_pipe;

    logic        CLK;
    logic        ARST_N;
    logic        EN;
    logic        CLR;
    logic        IN_VALID;
    logic [17:0] A;
    logic [17:0] B;
    logic [39:0] C;
    logic        ACC_LOAD;

    logic        ov_m0, ov_m1, ov_m2, ov_m2s, ov_u;
    logic [39:0] p_m0, p_m1, p_m2, p_m2s, p_u;
    logic        f_m0, f_m1, f_m2, f_m2s, f_u;

    int n_chk = 0;
    int n_err = 0;

    zeroasic_dsp_macc_pipe #(.MODE(0)) u_m0 (
        .CLK(CLK), .ARST_N(ARST_N), .EN(EN), .CLR(CLR), .IN_VALID(IN_VALID),
        .A(A), .B(B), .C(C), .ACC_LOAD(ACC_LOAD),
        .OUT_VALID(ov_m0), .P(p_m0), .OVF(f_m0));

    zeroasic_dsp_macc_pipe #(.MODE(1)) u_m1 (
        .CLK(CLK), .ARST_N(ARST_N), .EN(EN), .CLR(CLR), .IN_VALID(IN_VALID),
        .A(A), .B(B), .C(C), .ACC_LOAD(ACC_LOAD),
        .OUT_VALID(ov_m1), .P(p_m1), .OVF(f_m1));

    zeroasic_dsp_macc_pipe #(.MODE(2), .SATURATE(0)) u_m2 (
        .CLK(CLK), .ARST_N(ARST_N), .EN(EN), .CLR(CLR), .IN_VALID(IN_VALID),
        .A(A), .B(B), .C(C), .ACC_LOAD(ACC_LOAD),
        .OUT_VALID(ov_m2), .P(p_m2), .OVF(f_m2));

    zeroasic_dsp_macc_pipe #(.MODE(2), .SATURATE(1)) u_m2s (
        .CLK(CLK), .ARST_N(ARST_N), .EN(EN), .CLR(CLR), .IN_VALID(IN_VALID),
        .A(A), .B(B), .C(C), .ACC_LOAD(ACC_LOAD),
        .OUT_VALID(ov_m2s), .P(p_m2s), .OVF(f_m2s));

    zeroasic_dsp_macc_pipe #(.MODE(0), .SIGNED(0), .IN_REG(0), .MULT_REG(0)) u_u (
        .CLK(CLK), .ARST_N(ARST_N), .EN(EN), .CLR(CLR), .IN_VALID(IN_VALID),
        .A(A), .B(B), .C(C), .ACC_LOAD(ACC_LOAD),
        .OUT_VALID(ov_u), .P(p_u), .OVF(f_u));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int                 a;
        int                 b;
        logic signed [63:0] c;
        logic               ld;
        logic signed [63:0] e0;   // MODE 0 signed
        logic signed [63:0] e1;   // MODE 1 signed
        logic signed [63:0] e2;   // MODE 2 running accumulator
        logic signed [63:0] eu;   // MODE 0 unsigned
    } vec_t;

    vec_t vt[10];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_p(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic send(input int a, input int b, input logic signed [63:0] c,
                        input logic ld);
        A        = 18'(a);
        B        = 18'(b);
        C        = c[39:0];
        ACC_LOAD = ld;
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
    endtask

    initial begin
        // a, b, c, ld, m0, m1, m2 (accumulated), unsigned m0
        vt[0] = '{3, -5, 64'sd0, 1'b0, -64'sd15, -64'sd15, -64'sd15, 64'sd786417};
        vt[1] = '{2, 3, 64'sd10, 1'b1, 64'sd6, 64'sd16, 64'sd16, 64'sd6};
        vt[2] = '{-4, 4, 64'sd1, 1'b0, -64'sd16, -64'sd15, 64'sd0, 64'sd1048560};
        vt[3] = '{-131072, -131072, 64'sd0, 1'b0, 64'sd17179869184, 64'sd17179869184,
                  64'sd17179869184, 64'sd17179869184};
        vt[4] = '{131071, -131072, -64'sd1000, 1'b1, -64'sd17179738112,
                  -64'sd17179739112, -64'sd17179739112, 64'sd17179738112};
        vt[5] = '{0, 0, 64'sd0, 1'b1, 64'sd0, 64'sd0, 64'sd0, 64'sd0};
        vt[6] = '{1, 1, 64'sd100, 1'b1, 64'sd1, 64'sd101, 64'sd101, 64'sd1};
        vt[7] = '{2, 3, 64'sd0, 1'b0, 64'sd6, 64'sd6, 64'sd107, 64'sd6};
        vt[8] = '{4, 5, 64'sd0, 1'b0, 64'sd20, 64'sd20, 64'sd127, 64'sd20};
        vt[9] = '{0, 0, 64'sd0, 1'b1, 64'sd0, 64'sd0, 64'sd0, 64'sd0};

        // Reset held with random activity on the inputs.
        ARST_N = 1'b0;
        EN = 1'b1; CLR = 1'b0; IN_VALID = 1'b0;
        A = '0; B = '0; C = '0; ACC_LOAD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A        = 18'($urandom);
            B        = 18'($urandom);
            C        = {8'($urandom), 32'($urandom)};
            ACC_LOAD = 1'($urandom);
            IN_VALID = 1'($urandom);
            EN       = 1'($urandom);
            CLR      = 1'($urandom);
            step();
        end
        chk_b("rst_ov_m0", ov_m0, 1'b0);
        chk_p("rst_p_m0", 64'($signed(p_m0)), 64'sd0);
        chk_b("rst_ovf_m1", f_m1, 1'b0);
        chk_p("rst_p_m2", 64'($signed(p_m2)), 64'sd0);
        chk_b("rst_ov_u", ov_u, 1'b0);
        chk_p("rst_p_u", {24'd0, p_u}, 64'sd0);
        EN = 1'b1; CLR = 1'b0; IN_VALID = 1'b0;
        ARST_N = 1'b1;

        // Table: one isolated sample per row, checked at each latency edge.
        for (int i = 0; i < 10; i++) begin
            send(vt[i].a, vt[i].b, vt[i].c, vt[i].ld);
            chk_b("tbl_ov_u_edge1", ov_u, 1'b1);
            chk_p("tbl_p_u", {24'd0, p_u}, vt[i].eu);
            chk_b("tbl_ov_m0_edge1", ov_m0, 1'b0);
            step();
            chk_b("tbl_ov_m0_edge2", ov_m0, 1'b0);
            step();
            chk_b("tbl_ov_m0_edge3", ov_m0, 1'b1);
            chk_p("tbl_p_m0", 64'($signed(p_m0)), vt[i].e0);
            chk_p("tbl_p_m1", 64'($signed(p_m1)), vt[i].e1);
            chk_p("tbl_p_m2", 64'($signed(p_m2)), vt[i].e2);
            chk_p("tbl_p_m2s", 64'($signed(p_m2s)), vt[i].e2);
            chk_b("tbl_ovf_m1", f_m1, 1'b0);
            chk_b("tbl_ovf_m2", f_m2, 1'b0);
            chk_b("tbl_ovf_m0", f_m0, 1'b0);
        end

        // MODE 1 back-to-back samples.
        send(2, 3, 64'sd10, 1'b0);
        send(-4, 4, 64'sd1, 1'b0);
        step();
        chk_b("b2b_ov1", ov_m1, 1'b1);
        chk_p("b2b_p1", 64'($signed(p_m1)), 64'sd16);
        step();
        chk_b("b2b_ov2", ov_m1, 1'b1);
        chk_p("b2b_p2", 64'($signed(p_m1)), -64'sd15);
        step();
        chk_b("b2b_ov3", ov_m1, 1'b0);
        chk_p("b2b_p3", 64'($signed(p_m1)), -64'sd15);

        // Stall mid-pipeline; IN_VALID during the stall must be ignored.
        send(7, -9, 64'sd0, 1'b0);
        EN = 1'b0;
        A = 18'(100); B = 18'(100); IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_b("stall_ov", ov_m0, 1'b0);
            chk_p("stall_p", 64'($signed(p_m0)), -64'sd16);
        end
        EN = 1'b1; IN_VALID = 1'b0;
        step();
        chk_b("stall_edge2_ov", ov_m0, 1'b0);
        step();
        chk_b("stall_edge3_ov", ov_m0, 1'b1);
        chk_p("stall_edge3_p", 64'($signed(p_m0)), -64'sd63);
        EN = 1'b0;
        step();
        step();
        chk_b("stall_hold_ov", ov_m0, 1'b1);
        chk_p("stall_hold_p", 64'($signed(p_m0)), -64'sd63);
        EN = 1'b1;
        step();
        chk_b("stall_fall_ov", ov_m0, 1'b0);
        step();
        chk_b("stall_noaccept_ov", ov_m0, 1'b0);

        // Saturation / wrap: 32 products of 131071^2 still fit, the 33rd does not.
        send(131071, 131071, 64'sd0, 1'b1);
        for (int i = 0; i < 31; i++) send(131071, 131071, 64'sd0, 1'b0);
        step(); step(); step();
        chk_p("acc32_p_wrap", 64'($signed(p_m2)), 64'sd549747425312);
        chk_p("acc32_p_sat", 64'($signed(p_m2s)), 64'sd549747425312);
        chk_b("acc32_ovf_wrap", f_m2, 1'b0);
        chk_b("acc32_ovf_sat", f_m2s, 1'b0);
        send(131071, 131071, 64'sd0, 1'b0);
        step(); step(); step();
        chk_p("acc33_p_wrap", 64'($signed(p_m2)), -64'sd532584595423);
        chk_p("acc33_p_sat", 64'($signed(p_m2s)), 64'sd549755813887);
        chk_b("acc33_ovf_wrap", f_m2, 1'b1);
        chk_b("acc33_ovf_sat", f_m2s, 1'b1);
        send(131071, 131071, 64'sd0, 1'b0);
        step(); step(); step();
        chk_p("acc34_p_wrap", 64'($signed(p_m2)), -64'sd515404988382);
        chk_p("acc34_p_sat", 64'($signed(p_m2s)), 64'sd549755813887);
        chk_b("acc34_ovf_sticky_wrap", f_m2, 1'b1);
        chk_b("acc34_ovf_sticky_sat", f_m2s, 1'b1);
        send(0, 0, 64'sd0, 1'b1);
        step(); step(); step();
        chk_p("reload_p", 64'($signed(p_m2)), 64'sd0);
        chk_b("reload_ovf_wrap", f_m2, 1'b0);
        chk_b("reload_ovf_sat", f_m2s, 1'b0);

        // CLR with two samples in flight and IN_VALID high.
        send(5, 5, 64'sd0, 1'b0);
        send(6, 6, 64'sd0, 1'b0);
        CLR = 1'b1;
        send(7, 7, 64'sd0, 1'b0);
        CLR = 1'b0;
        chk_b("clr_ov_m0", ov_m0, 1'b0);
        chk_p("clr_p_m0", 64'($signed(p_m0)), 64'sd0);
        chk_b("clr_ov_u", ov_u, 1'b0);
        chk_p("clr_p_u", {24'd0, p_u}, 64'sd0);
        chk_p("clr_p_m2", 64'($signed(p_m2)), 64'sd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_b("clr_after_ov_m0", ov_m0, 1'b0);
            chk_b("clr_after_ov_m2", ov_m2, 1'b0);
            chk_p("clr_after_p_m2", 64'($signed(p_m2)), 64'sd0);
        end

        // Asynchronous reset mid-accumulation.
        send(1, 1, 64'sd100, 1'b1);
        send(2, 3, 64'sd0, 1'b0);
        step();
        chk_p("ar_p101", 64'($signed(p_m2)), 64'sd101);
        step();
        chk_p("ar_p107", 64'($signed(p_m2)), 64'sd107);
        send(4, 5, 64'sd0, 1'b0);
        ARST_N = 1'b0;
        #1;
        chk_p("ar_async_p_m2", 64'($signed(p_m2)), 64'sd0);
        chk_b("ar_async_ov_m2", ov_m2, 1'b0);
        chk_b("ar_async_ovf_m2", f_m2, 1'b0);
        chk_p("ar_async_p_m0", 64'($signed(p_m0)), 64'sd0);
        step();
        ARST_N = 1'b1;
        send(2, 3, 64'sd0, 1'b0);
        step();
        step();
        chk_b("ar_restart_ov", ov_m2, 1'b1);
        chk_p("ar_restart_p", 64'($signed(p_m2)), 64'sd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
